// File: rtl/psd_seg_accumulator_if.sv
// Bin-stream handshake bundle: FFT core -> PSD accumulator -> PSD post-processing.
// The slave modport is the accumulator's view; master is the surrounding logic's view.
interface psd_seg_accumulator_if #(
    parameter int DATA_W  = 16,
    parameter int LOGN    = 9,
    parameter int LOG_SEG = 4,
    parameter int OUT_W   = 2*DATA_W+1
);
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_psd;
    logic [LOGN-1:0]          out_bin;
    logic                     out_last;
    logic [LOG_SEG-1:0]       seg_idx;
    logic                     done;

    modport slave (
        input  start, in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_psd, out_bin, out_last, seg_idx, done
    );

    modport master (
        output start, in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_psd, out_bin, out_last, seg_idx, done
    );
endinterface

// File: rtl/psd_seg_accumulator.sv
// Purpose: per-bin |X|^2 accumulation over 2^LOG_SEG FFT segments, streams the averaged periodogram.
// Latency: 1-cycle read-modify-write per bin; first PSD word 2 cycles after the output phase begins.
// Backpressure: input always ready while accumulating; output holds data while out_ready is low.
// PSD_ONESIDED_EN (define) selects a one-sided PSD of N_POINTS/2+1 bins.
module psd_seg_accumulator #(
    parameter int N_POINTS = 512,
    parameter int LOGN     = 9,
    parameter int DATA_W   = 16,
    parameter int LOG_SEG  = 4,
    parameter int ACC_W    = 2*DATA_W+LOG_SEG,
    parameter int OUT_W    = 2*DATA_W+1
) (
    input logic                  clk,
    input logic                  rst_n,
    psd_seg_accumulator_if.slave bus
);
    localparam int PWR_W = 2*DATA_W;
    localparam logic [LOGN-1:0]    BIN_MAX = LOGN'(N_POINTS-1);
    localparam logic [LOG_SEG-1:0] SEG_MAX = LOG_SEG'((1 << LOG_SEG) - 1);
`ifdef PSD_ONESIDED_EN
    localparam logic [LOGN-1:0]    LAST_BIN = LOGN'(N_POINTS/2);
`else
    localparam logic [LOGN-1:0]    LAST_BIN = BIN_MAX;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUTPUT} state_t;
    state_t state, state_nxt;

    logic [LOGN-1:0]         bin_cnt;
    logic [LOG_SEG-1:0]      seg_cnt;
    logic                    drain_cnt;
    logic                    accept, last_accept, last_hs;

    logic signed [PWR_W-1:0] sq_re, sq_im;
    logic [PWR_W-1:0]        pwr, pwr_q;
    logic                    wr_en, wr_seg0;
    logic [LOGN-1:0]         wr_addr;

    logic [ACC_W-1:0]        ram [N_POINTS];
    logic                    rd_en, rd_en_out;
    logic [LOGN-1:0]         rd_addr;
    logic [ACC_W-1:0]        rd_data;

    logic [LOGN-1:0]         rd_ptr, rd_bin;
    logic                    rd_issued_all, rd_vld, out_adv;
    logic [PWR_W-1:0]        avg;
    logic [OUT_W-1:0]        psd_nxt;

    // Squares are formed at full width; the sum of two 2^30 maxima is exactly 2^31 unsigned.
    assign sq_re = PWR_W'(bus.in_re) * PWR_W'(bus.in_re);
    assign sq_im = PWR_W'(bus.in_im) * PWR_W'(bus.in_im);
    assign pwr   = $unsigned(sq_re) + $unsigned(sq_im);

    assign bus.in_ready = (state == S_ACCUM);
    assign bus.seg_idx  = seg_cnt;
    assign accept       = (state == S_ACCUM) && bus.in_valid;
    assign last_accept  = accept && (bin_cnt == BIN_MAX) && (seg_cnt == SEG_MAX);
    assign out_adv      = !bus.out_valid || bus.out_ready;
    assign last_hs      = (state == S_OUTPUT) && bus.out_valid && bus.out_ready && bus.out_last;

    // The single read port serves the accumulate read and the output prefetch; they never overlap.
    assign rd_en_out = (state == S_OUTPUT) && !rd_issued_all && (!rd_vld || out_adv);
    assign rd_en     = accept || rd_en_out;
    assign rd_addr   = accept ? bin_cnt : rd_ptr;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start)  state_nxt = S_ACCUM;
            S_ACCUM:  if (last_accept) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt)  state_nxt = S_OUTPUT;
            S_OUTPUT: if (last_hs)    state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bin_cnt   <= '0;
            seg_cnt   <= '0;
            drain_cnt <= 1'b0;
            bus.done  <= 1'b0;
            wr_en     <= 1'b0;
            wr_seg0   <= 1'b0;
            wr_addr   <= '0;
            pwr_q     <= '0;
        end else begin
            state     <= state_nxt;
            bus.done  <= last_hs;
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
            if ((state == S_IDLE) && bus.start) begin
                bin_cnt <= '0;
                seg_cnt <= '0;
            end else if (accept) begin
                bin_cnt <= (bin_cnt == BIN_MAX) ? '0 : bin_cnt + 1'b1;
                if (bin_cnt == BIN_MAX)
                    seg_cnt <= seg_cnt + 1'b1;
            end
            wr_en <= accept;
            if (accept) begin
                wr_addr <= bin_cnt;
                pwr_q   <= pwr;
                wr_seg0 <= (seg_cnt == '0);
            end
        end
    end

    // Segment 0 overwrites, which doubles as the accumulator clear for every run.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] <= wr_seg0 ? ACC_W'(pwr_q) : rd_data + ACC_W'(pwr_q);
        if (rd_en)
            rd_data <= ram[rd_addr];
    end

    assign avg = PWR_W'(rd_data >> LOG_SEG);
`ifdef PSD_ONESIDED_EN
    assign psd_nxt = ((rd_bin != '0) && (rd_bin != LAST_BIN)) ? OUT_W'({avg, 1'b0}) : OUT_W'(avg);
`else
    assign psd_nxt = OUT_W'(avg);
`endif

    // rd_data acts as the prefetch stage in front of the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            rd_issued_all <= 1'b0;
            rd_vld        <= 1'b0;
            rd_bin        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_psd   <= '0;
            bus.out_bin   <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (state == S_DRAIN) begin
                rd_ptr        <= '0;
                rd_issued_all <= 1'b0;
            end else if (rd_en_out) begin
                rd_ptr        <= rd_ptr + 1'b1;
                rd_issued_all <= (rd_ptr == LAST_BIN);
            end
            if (rd_en_out) begin
                rd_vld <= 1'b1;
                rd_bin <= rd_ptr;
            end else if (out_adv) begin
                rd_vld <= 1'b0;
            end
            if (out_adv) begin
                bus.out_valid <= rd_vld;
                if (rd_vld) begin
                    bus.out_psd  <= psd_nxt;
                    bus.out_bin  <= rd_bin;
                    bus.out_last <= (rd_bin == LAST_BIN);
                end else begin
                    bus.out_last <= 1'b0;
                end
            end
        end
    end
endmodule
